uart_rx: RTL and testbench

- UART receiver. It is the counterpart of the team's UART TX path: start bit, DATA_WIDTH data bits LSB first, optional parity bit, one stop bit.
- Oversamples RX_IN by a runtime Prescale and takes a majority vote of three mid-bit samples.
- Deserialises the frame and checks it, then presents the byte with a one-cycle valid pulse.
- Sits between the async-serial pad (already synchronised upstream) and the system's RX data consumer.

---
 rtl/uart_rx.sv | 116 +++++++++++
 tb/tb_uart_rx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: oversampled by a runtime Prescale with a 3-sample majority per bit.
// Frame layout is start, DATA_WIDTH bits LSB first, optional parity, one stop bit.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [4:0] IDLE   = 5'b00001;
    localparam logic [4:0] START  = 5'b00010;
    localparam logic [4:0] DATA   = 5'b00100;
    localparam logic [4:0] PARITY = 5'b01000;
    localparam logic [4:0] STOP   = 5'b10000;

    logic [4:0]            state;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [2:0]            smp;
    logic                  pen_q, ptyp_q, frame_bad;

    logic [PRESCALE_W-1:0] half;
    logic                  last_edge, maj;

    assign half      = Prescale >> 1;
    assign last_edge = (edge_cnt == Prescale - PRESCALE_W'(1));
    assign maj       = (smp[0] & smp[1]) | (smp[1] & smp[2]) | (smp[0] & smp[2]);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            smp        <= '0;
            pen_q      <= 1'b0;
            ptyp_q     <= 1'b0;
            frame_bad  <= 1'b0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;

            if (state != IDLE) begin
                edge_cnt <= last_edge ? '0 : edge_cnt + PRESCALE_W'(1);
                if (edge_cnt == half - PRESCALE_W'(1)) smp[0] <= RX_IN;
                else if (edge_cnt == half)             smp[1] <= RX_IN;
                else if (edge_cnt == half + PRESCALE_W'(1)) smp[2] <= RX_IN;
            end

            case (state)
                IDLE: begin
                    // The first low cycle is edge 0 of the start bit.
                    if (!RX_IN) begin
                        state    <= START;
                        edge_cnt <= PRESCALE_W'(1);
                        bit_cnt  <= '0;
                        pen_q    <= PAR_EN;
                        ptyp_q   <= PAR_TYP;
                    end else begin
                        edge_cnt <= '0;
                    end
                end
                START: if (last_edge) begin
                    state   <= maj ? IDLE : DATA;
                    bit_cnt <= '0;
                end
                DATA: if (last_edge) begin
                    shreg <= {maj, shreg[DATA_WIDTH-1:1]};
                    if (bit_cnt == BW'(DATA_WIDTH-1)) begin
                        state   <= pen_q ? PARITY : STOP;
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + BW'(1);
                    end
                end
                PARITY: if (last_edge) begin
                    if (((^shreg) ^ ptyp_q) != maj) begin
                        frame_bad <= 1'b1;
                        par_err   <= 1'b1;
                    end
                    state <= STOP;
                end
                STOP: if (last_edge) begin
                    if (!maj) begin
                        stp_err <= 1'b1;
                    end else if (!frame_bad) begin
                        P_DATA     <= shreg;
                        data_valid <= 1'b1;
                    end
                    frame_bad <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    edge_cnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed frames for uart_rx; expected pulses go to a queue that a negedge monitor drains.
module tb_uart_rx;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RX_IN = 1'b1;
    logic [5:0] Prescale = 6'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [7:0] P_DATA;
    logic       data_valid, par_err, stp_err;

    uart_rx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .P_DATA(P_DATA),
        .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // kind: 0 = data_valid, 1 = par_err, 2 = stp_err; at = absolute cycle of the pulse
    typedef struct {
        int         kind;
        logic [7:0] data;
        int         at;
    } ev_t;
    ev_t q[$];

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_pdata = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Each pulse is observed at the negedge before the posedge numbered cyc+1.
    ev_t e;
    int  kind;
    always @(negedge CLK) begin
        if (!RST) begin
            if (data_valid && (par_err || stp_err)) begin
                n_err++;
                $display("FAIL exclusive: dv=%b pe=%b se=%b", data_valid, par_err, stp_err);
            end
            if (data_valid || par_err || stp_err) begin
                kind = data_valid ? 0 : (par_err ? 1 : 2);
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected pulse: kind %0d at cycle %0d, expected none", kind, cyc + 1);
                end else begin
                    e = q.pop_front();
                    check("pulse kind", kind, e.kind);
                    check("pulse cycle", cyc + 1, e.at);
                    if (e.kind == 0) begin
                        check("P_DATA", {24'd0, P_DATA}, {24'd0, e.data});
                        exp_pdata = e.data;
                    end
                end
            end else if (P_DATA !== exp_pdata) begin
                n_err++;
                $display("FAIL P_DATA hold: got %0h expected %0h", P_DATA, exp_pdata);
            end
        end
    end

    task automatic sync();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            RX_IN = v;
            sync();
        end
    endtask

    // gbit/gedge select one inverted cycle (frame bit index, edge); -1 for none.
    task automatic send_frame(input int p, input logic [7:0] d, input bit pen, input bit ptyp,
                              input bit pbit, input bit sbit, input int gbit, input int gedge,
                              input bit e_valid, input bit e_par, input bit e_stp);
        logic [11:0] fb;
        int          nb;
        int          start;
        logic        v;
        ev_t         x;
        nb       = 2 + 8 + (pen ? 1 : 0);
        fb       = '0;
        fb[0]    = 1'b0;
        for (int i = 0; i < 8; i++) fb[1+i] = d[i];
        if (pen) fb[9] = pbit;
        fb[nb-1] = sbit;
        Prescale = p[5:0];
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        start    = cyc + 1;
        if (e_par)   begin x.kind = 1; x.data = 8'h00; x.at = start + (nb - 1) * p; q.push_back(x); end
        if (e_valid) begin x.kind = 0; x.data = d;     x.at = start + nb * p;       q.push_back(x); end
        if (e_stp)   begin x.kind = 2; x.data = 8'h00; x.at = start + nb * p;       q.push_back(x); end
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < p; k++) begin
                v = fb[b];
                if (b == gbit && k == gedge) v = ~v;
                RX_IN = v;
                sync();
            end
        end
    endtask

    initial begin
        ev_t x;
        int  start;
        #2;
        check("reset P_DATA", {24'd0, P_DATA}, 32'd0);
        check("reset pulses", {29'd0, data_valid, par_err, stp_err}, 32'd0);
        sync();
        RST = 1'b0;
        drive(1'b1, 4);

        // P=8, no parity: 0xA5 at cycle 80
        send_frame(8, 8'hA5, 0, 0, 0, 1, -1, -1, 1, 0, 0);
        drive(1'b1, 5);
        // P=16 even parity: 0x3C has four ones -> parity 0 good, 1 bad (par_err at 160)
        send_frame(16, 8'h3C, 1, 0, 0, 1, -1, -1, 1, 0, 0);
        drive(1'b1, 5);
        send_frame(16, 8'h3C, 1, 0, 1, 1, -1, -1, 0, 1, 0);
        drive(1'b1, 5);
        // P=32 odd parity: 0x01 -> parity bit 0, stop 0 -> stp_err at 352
        send_frame(32, 8'h01, 1, 1, 0, 0, -1, -1, 0, 0, 1);
        drive(1'b1, 5);
        // Both bad at P=8: par_err at 80, stp_err at 88
        send_frame(8, 8'h3C, 1, 0, 1, 0, -1, -1, 0, 1, 1);
        drive(1'b1, 5);
        // Three-cycle start glitch: no pulses, then 0x5A
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        drive(1'b0, 3);
        drive(1'b1, 12);
        send_frame(8, 8'h5A, 0, 0, 0, 1, -1, -1, 1, 0, 0);
        // Back-to-back, no idle gap
        send_frame(8, 8'hFF, 0, 0, 0, 1, -1, -1, 1, 0, 0);
        send_frame(8, 8'h00, 0, 0, 0, 1, -1, -1, 1, 0, 0);
        drive(1'b1, 5);
        // Inverted cycle on the middle sample of data bit 3 (frame bit 4, edge 4)
        send_frame(8, 8'h96, 0, 0, 0, 1, 4, 4, 1, 0, 0);
        drive(1'b1, 5);
        // Line stuck low: stp_err at 80, restart at 80 reads all ones once the line rises
        start = cyc + 1;
        x.kind = 2; x.data = 8'h00; x.at = start + 80;  q.push_back(x);
        x.kind = 0; x.data = 8'hFF; x.at = start + 160; q.push_back(x);
        drive(1'b0, 90);
        drive(1'b1, 90);
        // Reset at cycle 40 of a frame
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        drive(1'b0, 8);
        drive(1'b1, 8);
        drive(1'b0, 24);
        exp_pdata = 8'h00;
        RST = 1'b1;
        #1;
        check("midreset P_DATA", {24'd0, P_DATA}, 32'd0);
        check("midreset pulses", {29'd0, data_valid, par_err, stp_err}, 32'd0);
        RX_IN = 1'b1;
        sync();
        sync();
        RST = 1'b0;
        drive(1'b1, 3);
        send_frame(8, 8'hC3, 0, 0, 0, 1, -1, -1, 1, 0, 0);
        drive(1'b1, 20);

        check("events outstanding", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: cycle %0d, expected completion", cyc);
        $fatal(1, "timeout");
    end
endmodule
